// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one imem request at a time,
// buffers {pc, inst} pairs for decode. Optional same-cycle bypass: IF_FETCH_QUEUE_BYPASS_EN.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ready,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state, state_nxt;
    logic [31:0]     fetch_pc;
    logic [31:0]     q_pc   [DEPTH];
    logic [31:0]     q_inst [DEPTH];
    logic [AW-1:0]   head, tail;
    logic            resp_ok, push, pop;

    assign imem_addr = fetch_pc;
    assign imem_req  = (state == IDLE) && (count < CW'(DEPTH)) && !redirect;
    assign resp_ok   = (state == WAIT) && imem_rvalid && !redirect;
    assign pop       = (count != '0) && out_ready && !redirect;

`ifdef IF_FETCH_QUEUE_BYPASS_EN
    logic bypass;
    // Empty queue: hand the response straight to decode; store it only if decode stalls.
    assign bypass    = resp_ok && (count == '0);
    assign push      = resp_ok && !(bypass && out_ready);
    assign out_valid = (count != '0) || bypass;
    assign out_pc    = bypass ? fetch_pc   : q_pc[head];
    assign out_inst  = bypass ? imem_rdata : q_inst[head];
`else
    assign push      = resp_ok;
    assign out_valid = (count != '0);
    assign out_pc    = q_pc[head];
    assign out_inst  = q_inst[head];
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (imem_req && imem_ready) state_nxt = WAIT;
            // A redirect that coincides with the response simply discards it.
            WAIT: if (imem_rvalid)            state_nxt = IDLE;
                  else if (redirect)          state_nxt = DROP;
            DROP: if (imem_rvalid)            state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect)
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (resp_ok)
                fetch_pc <= fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
            end
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_pc[tail]   <= fetch_pc;
                q_inst[tail] <= imem_rdata;
                tail         <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, fill/backpressure, redirects, reset mid-fetch.
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hCAFE, a[15:0]};
    endfunction

    // One accept cycle followed by one response cycle (zero-wait memory).
    task automatic fetch(input logic [31:0] a);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, a);
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word(a);
        tick();
        imem_rvalid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Streaming at one instruction per two cycles.
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("strm_req", 32'(imem_req), 32'd1);
            chk("strm_addr", imem_addr, 32'(4*i));
`ifndef IF_FETCH_QUEUE_BYPASS_EN
            if (i > 0) begin
                chk("strm_valid", 32'(out_valid), 32'd1);
                chk("strm_pc", out_pc, 32'(4*(i-1)));
                chk("strm_inst", out_inst, word(32'(4*(i-1))));
            end
`endif
            imem_ready = 1'b1;
            tick();
            imem_ready  = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata  = word(32'(4*i));
            #1;
            chk("strm_wait_req", 32'(imem_req), 32'd0);
`ifdef IF_FETCH_QUEUE_BYPASS_EN
            chk("byp_valid", 32'(out_valid), 32'd1);
            chk("byp_pc", out_pc, 32'(4*i));
            chk("byp_inst", out_inst, word(32'(4*i)));
            chk("byp_count", 32'(count), 32'd0);
`endif
            tick();
            imem_rvalid = 1'b0;
            #1;
        end
`ifndef IF_FETCH_QUEUE_BYPASS_EN
        chk("strm_valid2", 32'(out_valid), 32'd1);
        chk("strm_pc2", out_pc, 32'h8);
        chk("strm_inst2", out_inst, word(32'h8));
`else
        chk("byp_count_end", 32'(count), 32'd0);
`endif
        tick();
        chk("strm_drain", 32'(count), 32'd0);

        // Fill with decode stalled.
        rst = 1'b1; #1; rst = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst2_addr", imem_addr, 32'd0);
        for (int i = 0; i < 4; i++) fetch(32'(4*i));
        chk("full_count", 32'(count), 32'd4);
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_addr", imem_addr, 32'h10);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("full_hold", 32'(count), 32'd4);
        chk("full_head_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("pop_count", 32'(count), 32'd3);
        chk("pop_req", 32'(imem_req), 32'd1);
        chk("pop_addr", imem_addr, 32'h10);
        chk("pop_head_pc", out_pc, 32'h4);

        // Redirect while a request is outstanding: its response must be dropped.
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h107;
        #1;
        chk("redir_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("drop_count", 32'(count), 32'd0);
        chk("drop_valid", 32'(out_valid), 32'd0);
        chk("drop_addr", imem_addr, 32'h104);
        chk("drop_req", 32'(imem_req), 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("drop_discard", 32'(count), 32'd0);
        chk("drop_req2", 32'(imem_req), 32'd1);
        chk("drop_addr2", imem_addr, 32'h104);
        fetch(32'h104);
        chk("redir_valid", 32'(out_valid), 32'd1);
        chk("redir_pc", out_pc, 32'h104);
        chk("redir_inst", out_inst, word(32'h104));

        // Redirect coinciding with rvalid, two entries queued.
        fetch(32'h108);
        chk("two_count", 32'(count), 32'd2);
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        #1;
        chk("coin_count", 32'(count), 32'd0);
        chk("coin_valid", 32'(out_valid), 32'd0);
        chk("coin_req", 32'(imem_req), 32'd1);
        chk("coin_addr", imem_addr, 32'h200);

        // Reset while waiting with three entries queued; stray rvalid afterwards.
        for (int i = 0; i < 3; i++) fetch(32'h200 + 32'(4*i));
        chk("pre_rst_count", 32'(count), 32'd3);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("stray_count", 32'(count), 32'd0);
        chk("stray_valid", 32'(out_valid), 32'd0);
        chk("stray_addr", imem_addr, 32'h0);
        chk("stray_req", 32'(imem_req), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
